mlu_fill_ctrl: RTL and testbench

Sequencer for the mask-driven color fill datapath of the GPU. It accepts a fill command (tile base address, tile count, primary and secondary 12-bit RGB colors) and walks consecutive 64-pixel tiles. For each tile it reads the 4-bit R/G/B planes from the framebuffer and the 2-bit-per-pixel mask from mask memory, merges them through one internally instantiated `mlu_unit`, and writes the merged tile back. It sits between the GPU command decoder and the framebuffer/mask memory ports.

---
 rtl/mlu_fill_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mlu_fill_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlu_fill_ctrl.sv
// Mask-driven color fill sequencer: walks consecutive 64-pixel tiles, reads RGB planes and the
// 2-bit mask, merges them through mlu_unit and writes the merged tile back.
// Optional feature macro: MLU_FILL_SKIP_EN -- when defined, tiles whose mask is all zero are
// not written back (3 cycles per such tile instead of 4).

// Per-pixel color merge: 00 keep, 01 primary, 10 secondary, 11 black.
module mlu_unit #(
  parameter int unsigned NumPix = 64
) (
  input  logic [4*NumPix-1:0] r_i,
  input  logic [4*NumPix-1:0] g_i,
  input  logic [4*NumPix-1:0] b_i,
  input  logic [2*NumPix-1:0] mask_i,
  input  logic [11:0]         primary_i,
  input  logic [11:0]         secondary_i,
  output logic [4*NumPix-1:0] r_o,
  output logic [4*NumPix-1:0] g_o,
  output logic [4*NumPix-1:0] b_o
);

  // Start from the original planes, then override each pixel by its mask code.
  always_comb begin
    r_o = r_i;
    g_o = g_i;
    b_o = b_i;
    for (int unsigned i = 0; i < NumPix; i++) begin
      case (mask_i[2*i +: 2])
        2'b01: begin
          r_o[4*i +: 4] = primary_i[11:8];
          g_o[4*i +: 4] = primary_i[7:4];
          b_o[4*i +: 4] = primary_i[3:0];
        end
        2'b10: begin
          r_o[4*i +: 4] = secondary_i[11:8];
          g_o[4*i +: 4] = secondary_i[7:4];
          b_o[4*i +: 4] = secondary_i[3:0];
        end
        2'b11: begin
          r_o[4*i +: 4] = 4'h0;
          g_o[4*i +: 4] = 4'h0;
          b_o[4*i +: 4] = 4'h0;
        end
        default: ;
      endcase
    end
  end

endmodule

module mlu_fill_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned COUNT_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_base,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic [11:0]        cmd_primary,
  input  logic [11:0]        cmd_secondary,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic               fb_rd_en,
  input  logic [255:0]       fb_rdata_r,
  input  logic [255:0]       fb_rdata_g,
  input  logic [255:0]       fb_rdata_b,
  output logic               fb_wr_en,
  output logic [255:0]       fb_wdata_r,
  output logic [255:0]       fb_wdata_g,
  output logic [255:0]       fb_wdata_b,
  output logic [ADDR_W-1:0]  mask_addr,
  output logic               mask_rd_en,
  input  logic [127:0]       mask_rdata,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] tiles_done
);

  typedef enum logic [2:0] {StIdle, StRead, StLatch, StMerge, StWrite, StDone} state_e;

  localparam logic [COUNT_W-1:0] OneCnt = COUNT_W'(1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [11:0]          primary_q, primary_d;
  logic [11:0]          secondary_q, secondary_d;
  logic [COUNT_W-1:0]   tiles_done_q, tiles_done_d;
  logic [255:0]         tile_r_q, tile_r_d, tile_g_q, tile_g_d, tile_b_q, tile_b_d;
  logic [127:0]         tile_mask_q, tile_mask_d;
  logic [255:0]         wdata_r_q, wdata_r_d, wdata_g_q, wdata_g_d, wdata_b_q, wdata_b_d;
  logic [255:0]         merged_r, merged_g, merged_b;
  logic [ADDR_W-1:0]    cur_addr;
  logic [COUNT_W-1:0]   tiles_inc;
  logic                 last_tile;
  logic                 skip_tile;

  // Address wraps modulo 2^ADDR_W by construction of the sum width.
  assign cur_addr  = base_q + ADDR_W'(tiles_done_q);
  assign tiles_inc = tiles_done_q + OneCnt;
  assign last_tile = (tiles_inc == count_q);

`ifdef MLU_FILL_SKIP_EN
  assign skip_tile = (tile_mask_q == '0);
`else
  assign skip_tile = 1'b0;
`endif

  mlu_unit #(
    .NumPix (64)
  ) u_mlu (
    .r_i         (tile_r_q),
    .g_i         (tile_g_q),
    .b_i         (tile_b_q),
    .mask_i      (tile_mask_q),
    .primary_i   (primary_q),
    .secondary_i (secondary_q),
    .r_o         (merged_r),
    .g_o         (merged_g),
    .b_o         (merged_b)
  );

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    count_d      = count_q;
    primary_d    = primary_q;
    secondary_d  = secondary_q;
    tiles_done_d = tiles_done_q;
    tile_r_d     = tile_r_q;
    tile_g_d     = tile_g_q;
    tile_b_d     = tile_b_q;
    tile_mask_d  = tile_mask_q;
    wdata_r_d    = wdata_r_q;
    wdata_g_d    = wdata_g_q;
    wdata_b_d    = wdata_b_q;

    cmd_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    fb_rd_en   = (state_q == StRead);
    mask_rd_en = (state_q == StRead);
    fb_wr_en   = (state_q == StWrite);

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          base_d       = cmd_base;
          count_d      = cmd_count;
          primary_d    = cmd_primary;
          secondary_d  = cmd_secondary;
          tiles_done_d = '0;
          state_d      = (cmd_count == '0) ? StDone : StRead;
        end
      end
      StRead: state_d = StLatch;
      StLatch: begin
        tile_r_d    = fb_rdata_r;
        tile_g_d    = fb_rdata_g;
        tile_b_d    = fb_rdata_b;
        tile_mask_d = mask_rdata;
        state_d     = StMerge;
      end
      StMerge: begin
        wdata_r_d = merged_r;
        wdata_g_d = merged_g;
        wdata_b_d = merged_b;
        if (skip_tile) begin
          tiles_done_d = tiles_inc;
          state_d      = last_tile ? StDone : StRead;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        tiles_done_d = tiles_inc;
        state_d      = last_tile ? StDone : StRead;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      base_q       <= '0;
      count_q      <= '0;
      primary_q    <= '0;
      secondary_q  <= '0;
      tiles_done_q <= '0;
      tile_r_q     <= '0;
      tile_g_q     <= '0;
      tile_b_q     <= '0;
      tile_mask_q  <= '0;
      wdata_r_q    <= '0;
      wdata_g_q    <= '0;
      wdata_b_q    <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      count_q      <= count_d;
      primary_q    <= primary_d;
      secondary_q  <= secondary_d;
      tiles_done_q <= tiles_done_d;
      tile_r_q     <= tile_r_d;
      tile_g_q     <= tile_g_d;
      tile_b_q     <= tile_b_d;
      tile_mask_q  <= tile_mask_d;
      wdata_r_q    <= wdata_r_d;
      wdata_g_q    <= wdata_g_d;
      wdata_b_q    <= wdata_b_d;
    end
  end

  assign fb_addr    = cur_addr;
  assign mask_addr  = cur_addr;
  assign fb_wdata_r = wdata_r_q;
  assign fb_wdata_g = wdata_g_q;
  assign fb_wdata_b = wdata_b_q;
  assign tiles_done = tiles_done_q;

endmodule

// File: tb/tb_mlu_fill_ctrl.sv
// Self-checking bench for mlu_fill_ctrl: memory model, event monitor, expectation queues,
// a table of fill commands plus hand-written reset / back-to-back sequences.
module tb_mlu_fill_ctrl;

`ifdef MLU_FILL_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [9:0]   cmd_base;
  logic [9:0]   cmd_count;
  logic [11:0]  cmd_primary;
  logic [11:0]  cmd_secondary;
  logic [9:0]   fb_addr;
  logic         fb_rd_en;
  logic [255:0] fb_rdata_r = '0;
  logic [255:0] fb_rdata_g = '0;
  logic [255:0] fb_rdata_b = '0;
  logic         fb_wr_en;
  logic [255:0] fb_wdata_r, fb_wdata_g, fb_wdata_b;
  logic [9:0]   mask_addr;
  logic         mask_rd_en;
  logic [127:0] mask_rdata = '0;
  logic         busy;
  logic         done;
  logic [9:0]   tiles_done;

  mlu_fill_ctrl #(
    .ADDR_W  (10),
    .COUNT_W (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base      (cmd_base),
    .cmd_count     (cmd_count),
    .cmd_primary   (cmd_primary),
    .cmd_secondary (cmd_secondary),
    .fb_addr       (fb_addr),
    .fb_rd_en      (fb_rd_en),
    .fb_rdata_r    (fb_rdata_r),
    .fb_rdata_g    (fb_rdata_g),
    .fb_rdata_b    (fb_rdata_b),
    .fb_wr_en      (fb_wr_en),
    .fb_wdata_r    (fb_wdata_r),
    .fb_wdata_g    (fb_wdata_g),
    .fb_wdata_b    (fb_wdata_b),
    .mask_addr     (mask_addr),
    .mask_rd_en    (mask_rd_en),
    .mask_rdata    (mask_rdata),
    .busy          (busy),
    .done          (done),
    .tiles_done    (tiles_done)
  );

  always #5 clk = ~clk;

  // Memories with 1-cycle read latency.
  logic [255:0] mem_r [1024];
  logic [255:0] mem_g [1024];
  logic [255:0] mem_b [1024];
  logic [127:0] mem_m [1024];

  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fb_rd_en) begin
      fb_rdata_r <= mem_r[fb_addr];
      fb_rdata_g <= mem_g[fb_addr];
      fb_rdata_b <= mem_b[fb_addr];
    end
    if (mask_rd_en) mask_rdata <= mem_m[mask_addr];
  end

  typedef struct {int edge_n; logic [9:0] addr; logic [9:0] maddr; logic both;} rd_ev_t;
  typedef struct {int edge_n; logic [9:0] addr; logic [255:0] r, g, b;} wr_ev_t;
  typedef struct {int rel; logic [9:0] addr;} exp_rd_t;
  typedef struct {int rel; logic [9:0] addr; logic [255:0] r, g, b;} exp_wr_t;

  rd_ev_t  rd_log[$];
  wr_ev_t  wr_log[$];
  int      done_log[$];
  int      accept_log[$];
  int      overlap_cnt = 0;
  exp_rd_t exp_rd_q[$];
  exp_wr_t exp_wr_q[$];

  // Monitor: samples on the falling edge; logs the rising edge at which each event is taken.
  always @(negedge clk) begin
    rd_ev_t re;
    wr_ev_t we;
    if (fb_rd_en || mask_rd_en) begin
      re.edge_n = cyc + 1;
      re.addr   = fb_addr;
      re.maddr  = mask_addr;
      re.both   = fb_rd_en & mask_rd_en;
      rd_log.push_back(re);
    end
    if (fb_wr_en) begin
      we.edge_n = cyc + 1;
      we.addr   = fb_addr;
      we.r      = fb_wdata_r;
      we.g      = fb_wdata_g;
      we.b      = fb_wdata_b;
      wr_log.push_back(we);
    end
    if (fb_wr_en && (fb_rd_en || mask_rd_en)) overlap_cnt = overlap_cnt + 1;
    if (done) done_log.push_back(cyc + 1);
    if (cmd_valid && cmd_ready && rst_n) accept_log.push_back(cyc + 1);
  end

  int checks = 0;
  int errors = 0;
  int rd_idx = 0, wr_idx = 0, done_idx = 0, acc_idx = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [255:0] r, g, b, input logic [127:0] m,
                                input logic [11:0] p, s,
                                output logic [255:0] ro, go, bo);
    ro = r; go = g; bo = b;
    for (int i = 0; i < 64; i++) begin
      case (m[2*i +: 2])
        2'b01: begin ro[4*i +: 4] = p[11:8]; go[4*i +: 4] = p[7:4]; bo[4*i +: 4] = p[3:0]; end
        2'b10: begin ro[4*i +: 4] = s[11:8]; go[4*i +: 4] = s[7:4]; bo[4*i +: 4] = s[3:0]; end
        2'b11: begin ro[4*i +: 4] = 4'h0; go[4*i +: 4] = 4'h0; bo[4*i +: 4] = 4'h0; end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] x;
    for (int j = 0; j < 8; j++) x[32*j +: 32] = $urandom;
    return x;
  endfunction

  // Pop expectations and compare against the logged strobes of one command.
  task automatic compare_logs(input string name, input int acc);
    exp_rd_t er;
    exp_wr_t ew;
    chk({name, ".rd_cnt"}, 256'(rd_log.size() - rd_idx), 256'(exp_rd_q.size()));
    chk({name, ".wr_cnt"}, 256'(wr_log.size() - wr_idx), 256'(exp_wr_q.size()));
    while (exp_rd_q.size() > 0) begin
      er = exp_rd_q.pop_front();
      if (rd_idx < rd_log.size()) begin
        chk({name, ".rd_addr"}, 256'(rd_log[rd_idx].addr), 256'(er.addr));
        chk({name, ".rd_maddr"}, 256'(rd_log[rd_idx].maddr), 256'(er.addr));
        chk({name, ".rd_both"}, 256'(rd_log[rd_idx].both), 256'(1));
        chk({name, ".rd_edge"}, 256'(rd_log[rd_idx].edge_n - acc), 256'(er.rel));
        rd_idx++;
      end
    end
    while (exp_wr_q.size() > 0) begin
      ew = exp_wr_q.pop_front();
      if (wr_idx < wr_log.size()) begin
        chk({name, ".wr_addr"}, 256'(wr_log[wr_idx].addr), 256'(ew.addr));
        chk({name, ".wr_edge"}, 256'(wr_log[wr_idx].edge_n - acc), 256'(ew.rel));
        chk({name, ".wr_r"}, wr_log[wr_idx].r, ew.r);
        chk({name, ".wr_g"}, wr_log[wr_idx].g, ew.g);
        chk({name, ".wr_b"}, wr_log[wr_idx].b, ew.b);
        wr_idx++;
      end
    end
    rd_idx = rd_log.size();
    wr_idx = wr_log.size();
    chk({name, ".overlap"}, 256'(overlap_cnt), 256'(0));
  endtask

  // Wait (bounded) for done, then check accept edge, done latency, tiles_done and strobes.
  task automatic finish_cmd(input string name, input int delta, input int tiles, input int acc);
    int t = 0;
    while (done_log.size() <= done_idx && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_log.size() <= done_idx) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got no done expected done within 300 cycles", name);
    end else begin
      chk({name, ".done_edge"}, 256'(done_log[done_idx] - acc), 256'(delta));
      done_idx++;
    end
    if (acc_idx < accept_log.size()) begin
      chk({name, ".accept"}, 256'(accept_log[acc_idx]), 256'(acc));
      acc_idx++;
    end else begin
      chk({name, ".accept_seen"}, 256'(0), 256'(1));
    end
    chk({name, ".tiles_done"}, 256'(tiles_done), 256'(tiles));
    @(posedge clk);
    #1;
    compare_logs(name, acc);
  endtask

  typedef struct {logic [9:0] base; logic [9:0] count; logic [11:0] prim, sec; int mkind;} vec_t;
  vec_t vecs[7];

  initial begin
    logic [255:0] r, g, b, er, eg, eb;
    logic [127:0] m;
    logic [9:0]   a;
    exp_wr_t      ew;
    int           acc, rel;
    bit           skip;

    // mkind: 0 random, 1 all 00, 2 all 01, 3 all 11, 4 first tile 00 then all 01
    vecs[0] = '{10'h3FE, 10'd3, 12'h123, 12'h456, 0};
    vecs[1] = '{10'h100, 10'd2, 12'hABC, 12'h0F0, 0};
    vecs[2] = '{10'h050, 10'd0, 12'hFFF, 12'h000, 0};
    vecs[3] = '{10'h200, 10'd1, 12'h777, 12'h888, 3};
    vecs[4] = '{10'h010, 10'd4, 12'h9A5, 12'h5A9, 0};
    vecs[5] = '{10'h300, 10'd2, 12'hE1D, 12'h333, 4};
    vecs[6] = '{10'h3FF, 10'd1, 12'h111, 12'h222, 1};

    // Reset with cmd_valid high and the single-tile command already offered.
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_base = 10'h005;
    cmd_count = 10'd1;
    cmd_primary = 12'hF00;
    cmd_secondary = 12'h0F0;
    mem_r[5] = {64{4'h5}};
    mem_g[5] = {64{4'h5}};
    mem_b[5] = {64{4'h5}};
    mem_m[5] = 128'h39;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst.ctrl", 256'({cmd_ready, busy, done, fb_rd_en, mask_rd_en, fb_wr_en}),
          256'(6'b100000));
      chk("rst.tiles_done", 256'(tiles_done), 256'(0));
      chk("rst.addr", 256'({fb_addr, mask_addr}), 256'(0));
      chk("rst.wdata", fb_wdata_r | fb_wdata_g | fb_wdata_b, 256'(0));
    end
    chk("rst.no_accept", 256'(accept_log.size()), 256'(0));

    // Single tile: hand-computed merged planes.
    er = {64{4'h5}}; eg = {64{4'h5}}; eb = {64{4'h5}};
    er[11:0] = 12'h00F;
    eg[11:0] = 12'h0F0;
    eb[11:0] = 12'h000;
    exp_rd_q.push_back('{1, 10'h005});
    exp_wr_q.push_back('{4, 10'h005, er, eg, eb});
    rst_n = 1'b1;
    acc = cyc + 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    finish_cmd("single", 5, 1, acc);

    // Table of commands; expectations built from the merge model.
    for (int v = 0; v < 7; v++) begin
      rel = 1;
      for (int t = 0; t < int'(vecs[v].count); t++) begin
        a = vecs[v].base + 10'(t);
        r = rand256(); g = rand256(); b = rand256();
        case (vecs[v].mkind)
          1: m = '0;
          2: m = {64{2'b01}};
          3: m = {64{2'b11}};
          4: m = (t == 0) ? '0 : {64{2'b01}};
          default: m = {$urandom, $urandom, $urandom, $urandom};
        endcase
        mem_r[a] = r; mem_g[a] = g; mem_b[a] = b; mem_m[a] = m;
        model(r, g, b, m, vecs[v].prim, vecs[v].sec, er, eg, eb);
        exp_rd_q.push_back('{rel, a});
        skip = SkipEn && (m == '0);
        if (!skip) begin
          ew.rel = rel + 3; ew.addr = a; ew.r = er; ew.g = eg; ew.b = eb;
          exp_wr_q.push_back(ew);
        end
        rel += skip ? 3 : 4;
      end
      cmd_base = vecs[v].base;
      cmd_count = vecs[v].count;
      cmd_primary = vecs[v].prim;
      cmd_secondary = vecs[v].sec;
      cmd_valid = 1'b1;
      acc = cyc + 1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      // Command inputs changing while busy must have no effect.
      cmd_base = ~cmd_base;
      cmd_count = 10'd7;
      cmd_primary = 12'h000;
      finish_cmd($sformatf("vec%0d", v), rel, int'(vecs[v].count), acc);
    end

    // count=0 followed immediately by a held command.
    cmd_base = 10'h123; cmd_count = 10'd0; cmd_valid = 1'b1;
    acc = cyc + 1;
    @(posedge clk);
    #1;
    cmd_base = 10'h040; cmd_count = 10'd1; cmd_primary = 12'h0AB; cmd_secondary = 12'hCD0;
    r = rand256(); g = rand256(); b = rand256(); m = {$urandom, $urandom, $urandom, $urandom};
    mem_r[10'h040] = r; mem_g[10'h040] = g; mem_b[10'h040] = b; mem_m[10'h040] = m;
    model(r, g, b, m, 12'h0AB, 12'hCD0, er, eg, eb);
    exp_rd_q.push_back('{1, 10'h040});
    exp_wr_q.push_back('{4, 10'h040, er, eg, eb});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (done_idx < done_log.size()) begin
      chk("b2b.zero_done", 256'(done_log[done_idx] - acc), 256'(1));
      done_idx++;
    end else begin
      chk("b2b.zero_done_seen", 256'(0), 256'(1));
    end
    if (acc_idx < accept_log.size()) begin
      chk("b2b.zero_accept", 256'(accept_log[acc_idx]), 256'(acc));
      acc_idx++;
    end
    chk("b2b.zero_no_strobe", 256'(rd_log.size() - rd_idx + wr_log.size() - wr_idx), 256'(0));
    finish_cmd("b2b", 5, 1, acc + 2);

    // Reset during MERGE of the second of four tiles.
    for (int t = 0; t < 4; t++) begin
      a = 10'h080 + 10'(t);
      mem_r[a] = rand256(); mem_g[a] = rand256(); mem_b[a] = rand256();
      mem_m[a] = {$urandom, $urandom, $urandom, $urandom};
    end
    model(mem_r[10'h080], mem_g[10'h080], mem_b[10'h080], mem_m[10'h080], 12'h5C3, 12'h3C5,
          er, eg, eb);
    exp_rd_q.push_back('{1, 10'h080});
    exp_rd_q.push_back('{5, 10'h081});
    exp_wr_q.push_back('{4, 10'h080, er, eg, eb});
    cmd_base = 10'h080; cmd_count = 10'd4; cmd_primary = 12'h5C3; cmd_secondary = 12'h3C5;
    cmd_valid = 1'b1;
    acc = cyc + 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst.tiles_done", 256'(tiles_done), 256'(0));
    chk("midrst.ctrl", 256'({cmd_ready, busy, done}), 256'(3'b100));
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst.no_done", 256'(done_log.size() - done_idx), 256'(0));
    if (acc_idx < accept_log.size()) begin
      chk("midrst.accept", 256'(accept_log[acc_idx]), 256'(acc));
      acc_idx++;
    end
    compare_logs("midrst", acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
